// File: rtl/leaky_envelope_detector_if.sv
// Sample/threshold bundle between the leaky integrator side and the
// envelope detector, plus the detector's event outputs.
interface leaky_envelope_detector_if #(
   parameter int W = 24
);
   logic signed [W-1:0] InSmooth;
   logic                InDv;
   logic signed [W-1:0] ThrHigh;
   logic signed [W-1:0] ThrLow;
   logic                Detect;
   logic                DetectRise;
   logic                DetectFall;
   logic signed [W-1:0] PeakOut;
   logic                PeakDv;

   modport master (
      output InSmooth, InDv, ThrHigh, ThrLow,
      input  Detect, DetectRise, DetectFall, PeakOut, PeakDv
   );

   modport slave (
      input  InSmooth, InDv, ThrHigh, ThrLow,
      output Detect, DetectRise, DetectFall, PeakOut, PeakDv
   );
endinterface

// File: rtl/leaky_envelope_detector.sv
// Hysteresis event detector with on/off debounce and per-event peak
// capture on the smoothed envelope stream.
module leaky_envelope_detector #(
   parameter int WI       = 12,
   parameter int WF       = 12,
   parameter int HOLD_ON  = 4,
   parameter int HOLD_OFF = 8
) (
   input logic Clk,
   input logic RESET,
   leaky_envelope_detector_if.slave io
);
   localparam int W = WI + WF;
   localparam logic [7:0] ON_N  = 8'(HOLD_ON);
   localparam logic [7:0] OFF_N = 8'(HOLD_OFF);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMING,
      S_ACTIVE,
      S_RELEASING
   } state_t;

   state_t              r_state;
   logic [7:0]          r_on_cnt;
   logic [7:0]          r_off_cnt;
   logic signed [W-1:0] r_peak;
   logic                r_detect;
   logic                r_rise;
   logic                r_fall;
   logic signed [W-1:0] r_pout;
   logic                r_pdv;

   state_t              w_state;
   logic [7:0]          w_on_cnt;
   logic [7:0]          w_off_cnt;
   logic signed [W-1:0] w_peak;
   logic                w_detect;
   logic                w_rise;
   logic                w_fall;
   logic signed [W-1:0] w_pout;
   logic                w_pdv;

   logic                w_above;
   logic                w_below;
   logic [7:0]          w_on_inc;
   logic [7:0]          w_off_inc;
   logic signed [W-1:0] w_peak_upd;

   // Signed threshold compares, saturating counter increments, running max
   always_comb begin
      w_above    = io.InSmooth >= io.ThrHigh;
      w_below    = io.InSmooth < io.ThrLow;
      w_on_inc   = (r_on_cnt == 8'hFF) ? 8'hFF : r_on_cnt + 8'd1;
      w_off_inc  = (r_off_cnt == 8'hFF) ? 8'hFF : r_off_cnt + 8'd1;
      w_peak_upd = (io.InSmooth > r_peak) ? io.InSmooth : r_peak;
   end

   // Next-state and output decode; only valid samples move the machine
   always_comb begin
      w_state   = r_state;
      w_on_cnt  = r_on_cnt;
      w_off_cnt = r_off_cnt;
      w_peak    = r_peak;
      w_detect  = r_detect;
      w_rise    = 1'b0;
      w_fall    = 1'b0;
      w_pout    = r_pout;
      w_pdv     = 1'b0;
      if (io.InDv) begin
         case (r_state)
            S_IDLE: begin
               if (w_above) begin
                  if (ON_N <= 8'd1) begin
                     w_state  = S_ACTIVE;
                     w_detect = 1'b1;
                     w_rise   = 1'b1;
                     w_peak   = io.InSmooth;
                     w_on_cnt = 8'd0;
                  end else begin
                     w_state  = S_ARMING;
                     w_on_cnt = 8'd1;
                  end
               end
            end
            S_ARMING: begin
               if (w_above) begin
                  if (w_on_inc >= ON_N) begin
                     w_state  = S_ACTIVE;
                     w_detect = 1'b1;
                     w_rise   = 1'b1;
                     w_peak   = io.InSmooth;
                     w_on_cnt = 8'd0;
                  end else begin
                     w_on_cnt = w_on_inc;
                  end
               end else begin
                  w_state  = S_IDLE;
                  w_on_cnt = 8'd0;
               end
            end
            S_ACTIVE: begin
               w_peak = w_peak_upd;
               if (w_below) begin
                  if (OFF_N <= 8'd1) begin
                     w_state   = S_IDLE;
                     w_detect  = 1'b0;
                     w_fall    = 1'b1;
                     w_pout    = w_peak_upd;
                     w_pdv     = 1'b1;
                     w_on_cnt  = 8'd0;
                     w_off_cnt = 8'd0;
                  end else begin
                     w_state   = S_RELEASING;
                     w_off_cnt = 8'd1;
                  end
               end
            end
            S_RELEASING: begin
               w_peak = w_peak_upd;
               if (w_below) begin
                  if (w_off_inc >= OFF_N) begin
                     w_state   = S_IDLE;
                     w_detect  = 1'b0;
                     w_fall    = 1'b1;
                     w_pout    = w_peak_upd;
                     w_pdv     = 1'b1;
                     w_on_cnt  = 8'd0;
                     w_off_cnt = 8'd0;
                  end else begin
                     w_off_cnt = w_off_inc;
                  end
               end else begin
                  w_state   = S_ACTIVE;
                  w_off_cnt = 8'd0;
               end
            end
            default: begin
               w_state   = S_IDLE;
               w_on_cnt  = 8'd0;
               w_off_cnt = 8'd0;
               w_detect  = 1'b0;
            end
         endcase
      end
   end

   // State, counters, peak and registered outputs
   always_ff @(posedge Clk or negedge RESET) begin
      if (!RESET) begin
         r_state   <= S_IDLE;
         r_on_cnt  <= 8'd0;
         r_off_cnt <= 8'd0;
         r_peak    <= '0;
         r_detect  <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
         r_pout    <= '0;
         r_pdv     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_on_cnt  <= w_on_cnt;
         r_off_cnt <= w_off_cnt;
         r_peak    <= w_peak;
         r_detect  <= w_detect;
         r_rise    <= w_rise;
         r_fall    <= w_fall;
         r_pout    <= w_pout;
         r_pdv     <= w_pdv;
      end
   end

   assign io.Detect     = r_detect;
   assign io.DetectRise = r_rise;
   assign io.DetectFall = r_fall;
   assign io.PeakOut    = r_pout;
   assign io.PeakDv     = r_pdv;
endmodule

// File: tb/tb_leaky_envelope_detector.sv
// Bench for leaky_envelope_detector: directed scenarios with literal
// expectations plus a randomized run against an event-level model.
module tb_leaky_envelope_detector;
   localparam int WI   = 12;
   localparam int WF   = 12;
   localparam int W    = WI + WF;
   localparam int HON  = 4;
   localparam int HOFF = 8;

   logic Clk = 1'b0;
   logic RESET;
   always #5 Clk = ~Clk;

   leaky_envelope_detector_if #(.W(W)) u_if ();

   leaky_envelope_detector #(
      .WI(WI), .WF(WF), .HOLD_ON(HON), .HOLD_OFF(HOFF)
   ) u_dut (
      .Clk(Clk),
      .RESET(RESET),
      .io(u_if)
   );

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // samples captured at the consuming clock edge
   bit                  c_rst;
   bit                  c_dv;
   logic signed [W-1:0] c_x, c_hi, c_lo;

   // event-level model: "in event" flag, length of the current
   // qualifying run, running max of the event, last reported peak
   bit                  m_act;
   int                  m_run;
   logic signed [W-1:0] m_peak, m_pout;
   bit                  e_rise, e_fall, e_pdv;

   initial forever begin
      @(posedge Clk);
      c_rst = RESET;
      c_dv  = u_if.InDv;
      c_x   = u_if.InSmooth;
      c_hi  = u_if.ThrHigh;
      c_lo  = u_if.ThrLow;
   end

   initial forever begin
      @(negedge Clk);
      e_rise = 0; e_fall = 0; e_pdv = 0;
      if (!RESET) begin
         m_act = 0; m_run = 0; m_peak = '0; m_pout = '0;
      end else if (c_rst && c_dv) begin
         if (!m_act) begin
            m_run = (c_x >= c_hi) ? m_run + 1 : 0;
            if (m_run >= HON) begin
               m_act = 1; e_rise = 1; m_peak = c_x; m_run = 0;
            end
         end else begin
            if (c_x > m_peak) m_peak = c_x;
            m_run = (c_x < c_lo) ? m_run + 1 : 0;
            if (m_run >= HOFF) begin
               m_act = 0; e_fall = 1; e_pdv = 1;
               m_pout = m_peak; m_run = 0;
            end
         end
      end
      if (mon_en) begin
         checks++;
         if ({u_if.Detect, u_if.DetectRise, u_if.DetectFall,
              u_if.PeakDv, u_if.PeakOut} !==
             {m_act, e_rise, e_fall, e_pdv, m_pout}) begin
            errors++;
            $display("FAIL model t=%0t got det=%b rise=%b fall=%b pdv=%b pk=%h want det=%b rise=%b fall=%b pdv=%b pk=%h",
                     $time, u_if.Detect, u_if.DetectRise, u_if.DetectFall,
                     u_if.PeakDv, u_if.PeakOut, m_act, e_rise, e_fall,
                     e_pdv, m_pout);
         end
      end
   end

   task automatic chk(input string n, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", n, act, exp);
      end
   endtask

   // called at a negedge; the sample is consumed at the next posedge
   // and the task returns at the following negedge
   task automatic drive(input bit dv, input logic signed [W-1:0] x);
      u_if.InDv     = dv;
      u_if.InSmooth = x;
      @(negedge Clk);
   endtask

   task automatic burst(input int n, input logic signed [W-1:0] x);
      for (int i = 0; i < n; i++) drive(1'b1, x);
   endtask

   localparam logic signed [W-1:0] P125 = 24'h001400;
   localparam logic signed [W-1:0] P025 = 24'h000400;

   initial begin
      int hv, lv, off;
      logic signed [W-1:0] x;
      RESET         = 1'b0;
      u_if.InDv     = 1'b0;
      u_if.InSmooth = '0;
      u_if.ThrHigh  = 24'h001000;
      u_if.ThrLow   = 24'h000800;
      @(negedge Clk);
      mon_en = 1'b1;
      @(negedge Clk);
      chk("rst_detect", {23'd0, u_if.Detect}, 24'd0);
      chk("rst_pulses", {21'd0, u_if.DetectRise, u_if.DetectFall,
                         u_if.PeakDv}, 24'd0);
      chk("rst_peak", u_if.PeakOut, 24'd0);
      RESET = 1'b1;
      drive(1'b0, '0);

      // rise after four samples of 1.25
      burst(3, P125);
      chk("rise_early", {23'd0, u_if.Detect}, 24'd0);
      drive(1'b1, P125);
      chk("rise_pulse", {23'd0, u_if.DetectRise}, 24'd1);
      chk("rise_level", {23'd0, u_if.Detect}, 24'd1);
      drive(1'b0, '0);
      chk("rise_width", {23'd0, u_if.DetectRise}, 24'd0);

      // hysteresis and peak
      drive(1'b1, 24'h001800);
      drive(1'b1, 24'h002000);
      drive(1'b1, 24'h000C00);
      drive(1'b1, 24'h00099A);
      chk("hyst_hold", {23'd0, u_if.Detect}, 24'd1);
      burst(7, P025);
      chk("off_7", {23'd0, u_if.Detect}, 24'd1);
      drive(1'b1, P025);
      chk("fall_pulse", {23'd0, u_if.DetectFall}, 24'd1);
      chk("fall_level", {23'd0, u_if.Detect}, 24'd0);
      chk("peak_dv", {23'd0, u_if.PeakDv}, 24'd1);
      chk("peak_val", u_if.PeakOut, 24'h002000);
      drive(1'b0, '0);
      chk("peak_dv_w", {23'd0, u_if.PeakDv}, 24'd0);
      chk("peak_hold", u_if.PeakOut, 24'h002000);

      // debounce: a 0.9 sample breaks the run
      burst(3, P125);
      drive(1'b1, 24'h000E66);
      chk("deb_none", {23'd0, u_if.Detect}, 24'd0);
      burst(3, P125);
      chk("deb_rearm", {23'd0, u_if.Detect}, 24'd0);
      drive(1'b1, P125);
      chk("deb_rise", {23'd0, u_if.DetectRise}, 24'd1);

      // release abort: sample equal to ThrLow is not below
      burst(5, P025);
      drive(1'b1, 24'h000800);
      chk("abort_eq", {23'd0, u_if.Detect}, 24'd1);
      burst(7, P025);
      chk("abort_cnt", {23'd0, u_if.Detect}, 24'd1);
      drive(1'b1, P025);
      chk("abort_end", {23'd0, u_if.DetectFall}, 24'd1);
      chk("abort_pk", u_if.PeakOut, 24'h001400);

      // gapped valid: only valid samples count
      for (int i = 0; i < 4; i++) begin
         int g;
         g = $urandom_range(0, 5);
         for (int j = 0; j < g; j++) drive(1'b0, P125);
         if (i == 3)
            chk("gap_pre", {23'd0, u_if.Detect}, 24'd0);
         drive(1'b1, P125);
      end
      chk("gap_rise", {23'd0, u_if.DetectRise}, 24'd1);
      for (int j = 0; j < 4; j++) drive(1'b0, P025);
      chk("gap_hold", {23'd0, u_if.Detect}, 24'd1);

      // reset while active
      #2 RESET = 1'b0;
      #1;
      chk("rst_mid_det", {23'd0, u_if.Detect}, 24'd0);
      chk("rst_mid_pk", u_if.PeakOut, 24'd0);
      chk("rst_mid_fall", {23'd0, u_if.DetectFall}, 24'd0);
      @(negedge Clk);
      @(negedge Clk);
      RESET = 1'b1;
      drive(1'b0, '0);
      burst(4, P125);
      chk("rearm_rise", {23'd0, u_if.DetectRise}, 24'd1);

      // signed thresholds; this also ends the open event
      u_if.ThrHigh = -24'sh000800;
      u_if.ThrLow  = -24'sh001000;
      burst(8, -24'sh001400);
      chk("neg_end", {23'd0, u_if.DetectFall}, 24'd1);
      burst(4, -24'sh000400);
      chk("neg_rise", {23'd0, u_if.DetectRise}, 24'd1);
      burst(8, -24'sh001400);
      chk("neg_fall", {23'd0, u_if.DetectFall}, 24'd1);
      chk("neg_peak", u_if.PeakOut, 24'hFFFC00);

      // randomized run against the model
      hv = 0; lv = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 400 == 0) begin
            hv = int'($urandom_range(0, 16384)) - 8192;
            lv = hv - int'($urandom_range(0, 4096));
            if ($urandom_range(0, 7) == 0) lv = hv + 256;
            u_if.ThrHigh = 24'(hv);
            u_if.ThrLow  = 24'(lv);
         end
         case ($urandom_range(0, 7))
            0: x = 24'(hv);
            1: x = 24'(lv);
            default: begin
               off = int'($urandom_range(0, 12288)) - 6144;
               x = 24'(hv + off);
            end
         endcase
         drive($urandom_range(0, 9) < 7, x);
      end

      drive(1'b0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
